// File: rtl/div_ctrl_pkg.sv
// Shared constants and state encoding for the multi-cycle divide sequencer.
// Imported by the control FSM and the single-iteration datapath step.
package div_ctrl_pkg;

  localparam int DOUBLE_REG_W = 64;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_t;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: compare-subtract the upper window against
// the divisor, then shift the working register left by one quotient bit.
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [2*DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0]   divisor,
  output logic [2*DATA_W:0]   dividend_next
);

  logic [DATA_W:0] diff;

  always_comb begin
    diff = {1'b0, dividend[2*DATA_W-1:DATA_W]} - {1'b0, divisor};
  end

  // A borrow out of the top bit means the window is smaller than the divisor.
  always_comb begin
    if (diff[DATA_W]) begin
      dividend_next = {dividend, 1'b0};
    end else begin
      dividend_next = {diff[DATA_W-1:0], dividend[DATA_W-1:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// Signed/unsigned restoring divide sequencer: FREE -> ON (DATA_W iterations) -> END,
// with a short BYZERO path, annul support and sign fixup of quotient/remainder.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                stallreq_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);

  div_state_t          state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [2*DATA_W:0]   dividend_reg, dividend_next;
  logic [DATA_W-1:0]   divisor_reg, divisor_next;
  logic                neg_q_reg, neg_q_next;
  logic                neg_r_reg, neg_r_next;
  logic [2*DATA_W-1:0] result_reg, result_next;
  logic                ready_reg, ready_next;

  logic [2*DATA_W:0]   step_out;
  logic [DATA_W-1:0]   op1_abs, op2_abs;
  logic [DATA_W-1:0]   q_raw, r_raw, q_fix, r_fix;

  div_step #(.DATA_W(DATA_W)) u_step (
    .dividend      (dividend_reg[2*DATA_W-1:0]),
    .divisor       (divisor_reg),
    .dividend_next (step_out)
  );

  // Negation wraps, so the most negative value maps onto itself.
  always_comb begin
    op1_abs = (signed_div_i && opdata1_i[DATA_W-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
    op2_abs = (signed_div_i && opdata2_i[DATA_W-1]) ? (~opdata2_i + 1'b1) : opdata2_i;
    q_raw   = dividend_reg[DATA_W-1:0];
    r_raw   = dividend_reg[2*DATA_W:DATA_W+1];
    q_fix   = neg_q_reg ? (~q_raw + 1'b1) : q_raw;
    r_fix   = neg_r_reg ? (~r_raw + 1'b1) : r_raw;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= DIV_FREE;
      cnt_reg      <= '0;
      dividend_reg <= '0;
      divisor_reg  <= '0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      result_reg   <= '0;
      ready_reg    <= DIV_RESULT_NOT_READY;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      dividend_reg <= dividend_next;
      divisor_reg  <= divisor_next;
      neg_q_reg    <= neg_q_next;
      neg_r_reg    <= neg_r_next;
      result_reg   <= result_next;
      ready_reg    <= ready_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    dividend_next = dividend_reg;
    divisor_next  = divisor_reg;
    neg_q_next    = neg_q_reg;
    neg_r_next    = neg_r_reg;
    result_next   = result_reg;
    ready_next    = ready_reg;

    case (state_reg)
      DIV_FREE: begin
        ready_next  = DIV_RESULT_NOT_READY;
        result_next = '0;
        if (start_i == DIV_START && !annul_i) begin
          if (opdata2_i == '0) begin
            state_next = DIV_BY_ZERO;
          end else begin
            state_next = DIV_ON;
            cnt_next   = '0;
          end
          dividend_next = {{DATA_W{1'b0}}, op1_abs, 1'b0};
          divisor_next  = op2_abs;
          neg_q_next    = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
          neg_r_next    = signed_div_i & opdata1_i[DATA_W-1];
        end
      end

      DIV_BY_ZERO: begin
        if (annul_i) begin
          state_next = DIV_FREE;
        end else begin
          state_next  = DIV_END;
          ready_next  = DIV_RESULT_READY;
          result_next = '0;
        end
      end

      DIV_ON: begin
        if (annul_i) begin
          state_next = DIV_FREE;
          cnt_next   = '0;
        end else if (cnt_reg != LAST_CNT) begin
          dividend_next = step_out;
          cnt_next      = cnt_reg + 1'b1;
        end else begin
          result_next = {r_fix, q_fix};
          ready_next  = DIV_RESULT_READY;
          cnt_next    = '0;
          state_next  = DIV_END;
        end
      end

      DIV_END: begin
        // EX holds start until it has consumed the result; annul has no effect here.
        if (start_i == DIV_STOP) begin
          state_next  = DIV_FREE;
          ready_next  = DIV_RESULT_NOT_READY;
          result_next = '0;
        end
      end

      default: begin
        state_next = DIV_FREE;
      end
    endcase
  end

  assign result_o   = result_reg;
  assign ready_o    = ready_reg;
  assign stallreq_o = start_i & ~ready_reg & ~annul_i;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: latency, signed/unsigned results, divide-by-zero,
// annul, asynchronous reset and result hold/release.
module tb_div_ctrl;

  logic        clk;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;
  logic        stallreq;

  int checks   = 0;
  int failures = 0;

  div_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready),
    .stallreq_o   (stallreq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start at E0, expect no result after E32 and the result after E33; start stays high.
  task automatic run_div(input string tag, input logic sd, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp);
    signed_div = sd;
    op1        = a;
    op2        = b;
    start      = 1'b1;
    tick();
    check1({tag, "_stall_busy"}, stallreq, 1'b1);
    repeat (32) tick();
    check1({tag, "_not_ready_e32"}, ready, 1'b0);
    tick();
    check1({tag, "_ready_e33"}, ready, 1'b1);
    check64({tag, "_result"}, result, exp);
    check1({tag, "_stall_done"}, stallreq, 1'b0);
    $display("txn %s: a=%h b=%h signed=%0d result=%h ready=%0d", tag, a, b, sd, result, ready);
  endtask

  initial begin
    logic seen_ready;
    rst        = 1'b0;
    signed_div = 1'b0;
    op1        = '0;
    op2        = '0;
    start      = 1'b0;
    annul      = 1'b0;

    repeat (2) tick();
    check1("rst_ready", ready, 1'b0);
    check64("rst_result", result, 64'h0);
    check1("rst_stall_idle", stallreq, 1'b0);
    start = 1'b1;
    #1;
    check1("rst_stall_comb", stallreq, 1'b1);
    start = 1'b0;
    rst   = 1'b1;
    tick();
    $display("txn reset: ready=%0d result=%h", ready, result);

    // 1: unsigned 100/7
    run_div("t1_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14});
    start = 1'b0;
    tick();
    check1("t1_release_ready", ready, 1'b0);
    check64("t1_release_result", result, 64'h0);

    // 2: signed -7/2 and unsigned 0xFFFFFFF9/2
    run_div("t2_signed", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    start = 1'b0;
    tick();
    run_div("t2_unsigned", 1'b0, 32'hFFFF_FFF9, 32'd2, {32'd1, 32'h7FFF_FFFC});
    start = 1'b0;
    tick();

    // 3: divide by zero
    signed_div = 1'b0;
    op1        = 32'd5;
    op2        = 32'd0;
    start      = 1'b1;
    tick();
    check1("t3_stall_e0", stallreq, 1'b1);
    check1("t3_not_ready_e0", ready, 1'b0);
    tick();
    check1("t3_ready_e1", ready, 1'b1);
    check64("t3_result", result, 64'h0);
    check1("t3_stall_e1", stallreq, 1'b0);
    $display("txn t3_div0: result=%h ready=%0d", result, ready);
    start = 1'b0;
    tick();
    check1("t3_release_ready", ready, 1'b0);

    // 4: annul at iteration 10, then a fresh full-latency divide
    op1   = 32'd100;
    op2   = 32'd7;
    start = 1'b1;
    tick();
    repeat (10) tick();
    annul = 1'b1;
    #1;
    check1("t4_stall_annul", stallreq, 1'b0);
    start = 1'b0;
    tick();
    annul      = 1'b0;
    seen_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ready) seen_ready = 1'b1;
    end
    check1("t4_no_ready_after_annul", seen_ready, 1'b0);
    $display("txn t4_annul: ready_seen=%0d", seen_ready);
    run_div("t4_restart", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14});
    start = 1'b0;
    tick();

    // 5: reset in the middle of a divide, then 9/3
    op1   = 32'd100;
    op2   = 32'd7;
    start = 1'b1;
    tick();
    repeat (20) tick();
    #2 rst = 1'b0;
    #1;
    check1("t5_midrst_ready", ready, 1'b0);
    check64("t5_midrst_result", result, 64'h0);
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    run_div("t5_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3});
    #2 rst = 1'b0;
    #1;
    check1("t5_endrst_ready", ready, 1'b0);
    check64("t5_endrst_result", result, 64'h0);
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check1("t5_no_residual_ready", ready, 1'b0);
    $display("txn t5_reset: ready=%0d result=%h", ready, result);

    // 6: most-negative / -1, held for three extra cycles then released
    run_div("t6_minint", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000});
    for (int i = 0; i < 3; i++) begin
      tick();
      check1("t6_hold_ready", ready, 1'b1);
      check64("t6_hold_result", result, {32'd0, 32'h8000_0000});
    end
    start = 1'b0;
    #1;
    check1("t6_ready_before_edge", ready, 1'b1);
    tick();
    check1("t6_release_ready", ready, 1'b0);
    check64("t6_release_result", result, 64'h0);
    $display("txn t6_release: ready=%0d result=%h", ready, result);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
